// File: rtl/cbus_sram_responder.sv
// cbus responder: services single/burst reads and byte-strobed writes from a 64-bit SRAM
// after LATENCY wait cycles. Optional macro CBUS_SRAM_BOUNDS_CHECK_EN enables range checking.

package cbus_pkg;
    typedef enum logic [1:0] { CBUS_FIXED = 2'd0, CBUS_INCR = 2'd1 } cbus_burst_e;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        cbus_burst_e burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_sram_responder
    import cbus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  cbus_req_t  req,
    output cbus_resp_t resp,
    output logic       oob
);
    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] OOB_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic [1:0] { S_IDLE, S_WAIT, S_BEAT, S_RECOVER } state_e;

    state_e      r_state, w_next;
    logic [3:0]  r_wait;
    logic [7:0]  r_beat, r_len, w_len, w_nbeat;
    logic        r_wr, w_wr;
    logic [63:0] r_addr, w_addr;
    cbus_burst_e r_burst, w_burst;
    logic        r_ready, r_last;
    logic [63:0] r_data;
    logic [63:0] r_mem [DEPTH_WORDS];
    logic [63:0] w_nword, w_cword;
    logic        w_noob, w_coob, w_wr_en;

    function automatic logic [63:0] word_num(input logic [63:0] addr, input cbus_burst_e burst,
                                             input logic [7:0] beat);
        word_num = ((addr - BASE_ADDR) >> 3) + ((burst == CBUS_INCR) ? {56'd0, beat} : 64'd0);
    endfunction

    // In IDLE the fields come live from req, so LATENCY=0 can load beat 0 at the acceptance edge.
    always_comb begin
        w_addr  = r_addr;
        w_len   = r_len;
        w_wr    = r_wr;
        w_burst = r_burst;
        if (r_state == S_IDLE) begin
            w_addr  = req.addr;
            w_len   = req.len;
            w_wr    = req.is_write;
            w_burst = req.burst;
        end
        w_nbeat = (r_state == S_BEAT) ? r_beat + 8'd1 : 8'd0;
        w_nword = word_num(w_addr, w_burst, w_nbeat);
        w_cword = word_num(r_addr, r_burst, r_beat);
    end

`ifdef CBUS_SRAM_BOUNDS_CHECK_EN
    logic r_oob;
    logic w_unused;

    function automatic logic out_of_range(input logic [63:0] addr, input logic [63:0] word);
        out_of_range = (addr < BASE_ADDR) || (word >= 64'(DEPTH_WORDS));
    endfunction

    assign w_noob   = out_of_range(w_addr, w_nword);
    assign w_coob   = r_oob;
    assign oob      = r_oob;
    assign w_unused = ^req.size;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_oob <= 1'b0;
        else     r_oob <= (w_next == S_BEAT) && w_noob;
    end
`else
    logic w_unused;
    assign w_noob   = 1'b0;
    assign w_coob   = 1'b0;
    assign oob      = 1'b0;
    assign w_unused = ^{req.size, w_nword[63:AW], w_cword[63:AW]};
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (req.valid) w_next = (LATENCY == 0) ? S_BEAT : S_WAIT;
            S_WAIT:    if (!req.valid) w_next = S_IDLE;
                       else if (r_wait <= 4'd1) w_next = S_BEAT;
            S_BEAT:    if (!req.valid) w_next = S_IDLE;
                       else if (r_beat == r_len) w_next = S_RECOVER;
            S_RECOVER: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wait  <= 4'd0;
            r_beat  <= 8'd0;
            r_ready <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= 64'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE)      r_wait <= 4'(LATENCY);
            else if (r_state == S_WAIT) r_wait <= r_wait - 4'd1;
            r_beat  <= (w_next == S_BEAT) ? w_nbeat : 8'd0;
            r_ready <= (w_next == S_BEAT);
            r_last  <= (w_next == S_BEAT) && (w_nbeat == w_len);
            if ((w_next == S_BEAT) && !w_wr)
                r_data <= w_noob ? OOB_DATA : r_mem[w_nword[AW-1:0]];
            else
                r_data <= 64'd0;
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && req.valid) begin
            r_addr  <= req.addr;
            r_len   <= req.len;
            r_wr    <= req.is_write;
            r_burst <= req.burst;
        end
    end

    // Write commits at the edge closing the beat; an aborted beat (valid low) is dropped.
    assign w_wr_en = (r_state == S_BEAT) && req.valid && r_wr && !w_coob;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (req.strobe[i]) r_mem[w_cword[AW-1:0]][i*8 +: 8] <= req.data[i*8 +: 8];
            end
        end
    end

    assign resp.ready = r_ready;
    assign resp.last  = r_last;
    assign resp.data  = r_data;

endmodule

// File: doc/cbus_sram_responder.md
# cbus_sram_responder

Responder end of the cbus request/response protocol: accepts `cbus_req_t` transactions from an initiator (MMU, D-cache, or arbiter output) and services them from an internal 64-bit-wide SRAM array with a programmable first-beat latency, returning `cbus_resp_t` beats. Supports single and burst (FIXED/INCR) reads and byte-strobed writes. Serves as the on-chip memory target for simulation and FPGA builds, and as the page-table backing store during MMU bring-up.

## Interface
- `DEPTH_WORDS`, 4096: number of 64-bit words; power of two, ≥ 2.
- `LATENCY`, 2: wait cycles between acceptance and first beat; 0..15.
- `BASE_ADDR`, 64'h8000_0000: byte address of word 0.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  `cbus_req_t`  valid, is_write, size, addr, strobe, data, len (beats−1), burst.
- `resp`  out  `cbus_resp_t`  ready (beat valid), last (final beat), data (read data).
- `oob`  out  1  one-cycle pulse on an out-of-range beat (see Configuration).

## Operation
- States: IDLE, WAIT, BEAT, RECOVER.
- IDLE: `resp` all zero. If `req.valid`=1, latch is_write, addr, len, burst; beat counter ← 0; wait counter ← LATENCY. Next state WAIT, or BEAT if LATENCY=0.
- WAIT: wait counter decrements each cycle; at 1 → BEAT. `resp.ready`=0.
- BEAT: `resp.ready`=1 every cycle, one beat per cycle, no stalls. `resp.last`=1 when beat counter == latched len. After the last beat → RECOVER.
- Beat address: word index = (addr − BASE_ADDR) >> 3 + (burst==INCR ? beat : 0). FIXED repeats the same word. Low 3 address bits are ignored.
- Read beat: `resp.data` = full aligned 64-bit word. `size` is not used for reads; the initiator extracts the bytes it needs.
- Write beat: at the edge that ends the beat cycle, write byte lanes where `req.strobe[i]`=1, using the live `req.data`/`req.strobe`. The initiator updates data per beat. `resp.data`=0 on writes.
- RECOVER: one cycle, `resp` zero, `req.valid` ignored, then IDLE. This supports initiators that keep `valid` high and change `addr` for back-to-back requests (page-table walk): the next request is sampled in IDLE from current fields.
- Abort: if `req.valid`=0 during WAIT or BEAT, go to IDLE at the next edge. The pending beat's write is not committed and `resp` is zero from that edge.
- Reset (any state, mid-burst included): state IDLE, `resp.ready`=`resp.last`=0, `resp.data`=0, `oob`=0, counters 0. The SRAM array is not cleared.

## Timing
- Acceptance edge E0 (IDLE, valid=1).
- First beat is visible in the cycle after edge E0+LATENCY. Beat k is visible after edge E0+LATENCY+k. Total occupancy is LATENCY+len+2 cycles including RECOVER.
- Read data is registered (array read at the edge preceding the beat). There is no combinational path from `req` to `resp`.
- Write-after-write to the same word in consecutive beats: both commit in order; the last one wins.
- A read beat following a write to the same word in a prior transaction returns the new data. This is guaranteed by RECOVER, so no bypass is needed.

## Configuration
- `CBUS_SRAM_BOUNDS_CHECK_EN` defined:
  - A beat whose index is outside [0, DEPTH_WORDS−1], or whose addr < BASE_ADDR, returns data 64'hDEAD_BEEF_DEAD_BEEF on reads and suppresses writes.
  - `oob` pulses high in that beat cycle.
  - The handshake is otherwise unchanged.
- Not defined:
  - Index is taken modulo DEPTH_WORDS (wrap-around); no aliasing check.
  - `oob` is tied 0.

## Test plan
- Single read, LATENCY=2, word 5 preloaded 64'h1122_3344_5566_7788, addr=BASE+0x28, len=0 → ready=last=1 in exactly one cycle, 3 cycles after acceptance, data=64'h1122_3344_5566_7788.
- INCR read burst len=3 from BASE+0x0, words 0–3 = 0..3 → 4 consecutive ready cycles, data 0,1,2,3, last only on 4th. FIXED burst with the same setup → data 0,0,0,0.
- Strobed write: word 2 = 64'hFFFF_FFFF_FFFF_FFFF, write data 64'h0, strobe 8'h0F → read back 64'hFFFF_FFFF_0000_0000.
- Back-to-back with valid held high: addr changes from BASE+0x0 to BASE+0x8 one cycle after last → second transaction returns word 1, not word 0; one zero-ready RECOVER cycle between them.
- Reset asserted mid-burst (beat 1 of len=3) → `resp` zero immediately (asynchronous). After release, a new read completes normally and earlier written data is intact.
- With `CBUS_SRAM_BOUNDS_CHECK_EN`, read at BASE+8·DEPTH_WORDS → data 64'hDEAD_BEEF_DEAD_BEEF, oob=1 for one cycle. Without the macro → word 0 returned, oob=0.
